// File: rtl/gray_code_source.sv
// Registered Gray-code word source with valid/ready output, up/down counting,
// synchronous load and optional saturation at the terminal count.
module gray_code_source #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic             fire_s;
    logic             free_s;
    logic             term_s;
    logic [WIDTH-1:0] bin_next_s;

    // Handshake qualifiers, terminal detection and the next binary count.
    always_comb begin
        fire_s     = valid_q & out_ready;
        free_s     = ~valid_q | out_ready;
        if (up_dn) begin
            term_s     = (bin_q == ONES_C);
            bin_next_s = bin_q + ONE_C;
        end else begin
            term_s     = (bin_q == ZERO_C);
            bin_next_s = bin_q - ONE_C;
        end
    end

    // Next-state selection: load beats emission, emission beats plain acceptance.
    always_comb begin
        bin_d   = bin_q;
        gray_d  = gray_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (load) begin
            bin_d   = load_val;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (en && free_s && !done_q) begin
            gray_d  = to_gray(bin_q);
            valid_d = 1'b1;
            wrap_d  = term_s;
            // A saturating counter parks on the terminal value instead of rolling over.
            if (SATURATE && term_s) begin
                done_d = 1'b1;
            end else begin
                bin_d = bin_next_s;
            end
        end else if (fire_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= ZERO_C;
            gray_q  <= ZERO_C;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign out_gray  = gray_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule
